// File: rtl/pooling_2x2_mc_stream.sv
// Streaming 2x2 / stride-2 MAX|AVG pooling over CH packed channels, with a half-width line buffer.
// Optional AVG datapath is built when POOL_AVG_EN is defined; otherwise MODE is ignored (MAX only).

module pool_lane #(
  parameter int DW     = 16,
  parameter int DEPTH  = 8,
  parameter int IW     = 3,
  parameter int SIGNED = 0
) (
  input  logic          CLK,
  input  logic          RSTn,
  input  logic          acc,
  input  logic          odd_col,
  input  logic          odd_row,
  input  logic          mode,
  input  logic [IW-1:0] idx,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] q_out
);
`ifdef POOL_AVG_EN
  localparam int PW = DW + 1;
`else
  localparam int PW = DW;
`endif

  logic [DW-1:0] h;
  logic [PW-1:0] lbuf [DEPTH];
  logic [PW-1:0] lb, p;
  logic [DW-1:0] mx_p, mx_q, q;

  // Strict greater-than, so on a tie the earlier operand is kept.
  function automatic logic gt(input logic [DW-1:0] a, input logic [DW-1:0] b);
    gt = (SIGNED != 0) ? ($signed(a) > $signed(b)) : (a > b);
  endfunction

`ifdef POOL_AVG_EN
  logic [DW+1:0] s4;

  function automatic logic [DW:0] ext1(input logic [DW-1:0] x);
    ext1 = (SIGNED != 0) ? {x[DW-1], x} : {1'b0, x};
  endfunction

  function automatic logic [DW+1:0] ext2(input logic [DW:0] x);
    ext2 = (SIGNED != 0) ? {x[DW], x} : {1'b0, x};
  endfunction

  always_comb begin
    lb   = lbuf[idx];
    mx_p = gt(din, h) ? din : h;
    p    = mode ? (ext1(h) + ext1(din)) : ext1(mx_p);
    mx_q = gt(p[DW-1:0], lb[DW-1:0]) ? p[DW-1:0] : lb[DW-1:0];
    s4   = ext2(lb) + ext2(p) + (DW+2)'(2);
    // Low DW bits of the >>2 are the same for logical and arithmetic shift.
    q    = mode ? s4[DW+1:2] : mx_q;
  end
`else
  logic unused_mode;
  assign unused_mode = mode;

  always_comb begin
    lb   = lbuf[idx];
    mx_p = gt(din, h) ? din : h;
    p    = mx_p;
    mx_q = gt(p, lb) ? p : lb;
    q    = mx_q;
  end
`endif

  // Hold register and line buffer carry no reset; a new frame overwrites them before use.
  always_ff @(posedge CLK) begin
    if (acc && !odd_col)
      h <= din;
    if (acc && odd_col && !odd_row)
      lbuf[idx] <= p;
  end

  always_ff @(posedge CLK) begin
    if (!RSTn)
      q_out <= '0;
    else if (acc && odd_col && odd_row)
      q_out <= q;
  end
endmodule

module pooling_2x2_mc_stream #(
  parameter int DW     = 16,
  parameter int CH     = 4,
  parameter int IMG_W  = 16,
  parameter int IMG_H  = 16,
  parameter int SIGNED = 0
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic             DIN_VALID,
  input  logic [CH*DW-1:0] DIN,
  input  logic             MODE,
  input  logic             SQUEEZE,
  output logic [CH*DW-1:0] OUT,
  output logic             VALID,
  output logic             LAST_IN_LINE,
  output logic             LAST_PIX,
  output logic             SQUEEZE_OUT,
  input  logic             NEXT_LAST_PIX
);
  localparam int CW    = $clog2(IMG_W);
  localparam int RW    = $clog2(IMG_H);
  localparam int DEPTH = IMG_W / 2;
  localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  logic [CW-1:0] col_cnt;
  logic [RW-1:0] row_cnt;
  logic          acc, odd_col, odd_row, col_last, row_last, fire;
  logic [IW-1:0] idx;
  logic [CH-1:0][DW-1:0] din_v, out_v;

  assign acc      = DIN_VALID | SQUEEZE;
  assign odd_col  = col_cnt[0];
  assign odd_row  = row_cnt[0];
  assign col_last = (col_cnt == COL_LAST);
  assign row_last = (row_cnt == ROW_LAST);
  assign fire     = acc & odd_col & odd_row;
  assign idx      = IW'(col_cnt >> 1);
  assign din_v    = DIN;
  assign OUT      = out_v;

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      col_cnt      <= '0;
      row_cnt      <= '0;
      VALID        <= 1'b0;
      LAST_IN_LINE <= 1'b0;
      LAST_PIX     <= 1'b0;
      SQUEEZE_OUT  <= 1'b0;
    end else begin
      VALID        <= fire;
      LAST_IN_LINE <= fire & col_last;
      LAST_PIX     <= fire & col_last & row_last;
      if (acc) begin
        if (col_last) begin
          col_cnt <= '0;
          row_cnt <= row_last ? '0 : row_cnt + 1'b1;
        end else begin
          col_cnt <= col_cnt + 1'b1;
        end
      end
      // Setting wins over the downstream clear when both land together.
      if (LAST_PIX)
        SQUEEZE_OUT <= 1'b1;
      else if (NEXT_LAST_PIX)
        SQUEEZE_OUT <= 1'b0;
    end
  end

  for (genvar k = 0; k < CH; k++) begin : g_lane
    pool_lane #(.DW(DW), .DEPTH(DEPTH), .IW(IW), .SIGNED(SIGNED)) u_lane (
      .CLK    (CLK),
      .RSTn   (RSTn),
      .acc    (acc),
      .odd_col(odd_col),
      .odd_row(odd_row),
      .mode   (MODE),
      .idx    (idx),
      .din    (din_v[k]),
      .q_out  (out_v[k])
    );
  end
endmodule

// File: tb/tb_pooling_2x2_mc_stream.sv
// Scoreboard bench for pooling_2x2_mc_stream: unsigned and signed instances share one stimulus stream.
module tb_pooling_2x2_mc_stream;
  localparam int DW = 8, CH = 4, W = 4, H = 4, PXW = CH * DW;

  logic CLK = 0, RSTn = 0, DIN_VALID = 0, SQUEEZE = 0, MODE = 0, NEXT_LAST_PIX = 0;
  logic [PXW-1:0] DIN = '0, out_u, out_s;
  logic v_u, lil_u, lp_u, sq_u, v_s, lil_s, lp_s, sq_s;

  pooling_2x2_mc_stream #(.DW(DW), .CH(CH), .IMG_W(W), .IMG_H(H), .SIGNED(0)) dut_u (
    .CLK(CLK), .RSTn(RSTn), .DIN_VALID(DIN_VALID), .DIN(DIN), .MODE(MODE), .SQUEEZE(SQUEEZE),
    .OUT(out_u), .VALID(v_u), .LAST_IN_LINE(lil_u), .LAST_PIX(lp_u), .SQUEEZE_OUT(sq_u),
    .NEXT_LAST_PIX(NEXT_LAST_PIX));

  pooling_2x2_mc_stream #(.DW(DW), .CH(CH), .IMG_W(W), .IMG_H(H), .SIGNED(1)) dut_s (
    .CLK(CLK), .RSTn(RSTn), .DIN_VALID(DIN_VALID), .DIN(DIN), .MODE(MODE), .SQUEEZE(SQUEEZE),
    .OUT(out_s), .VALID(v_s), .LAST_IN_LINE(lil_s), .LAST_PIX(lp_s), .SQUEEZE_OUT(sq_s),
    .NEXT_LAST_PIX(NEXT_LAST_PIX));

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  always @(posedge CLK) begin
    #1 NEXT_LAST_PIX = ($urandom_range(3) == 0);
  end

  typedef struct {
    int cyc;
    logic [PXW-1:0] du, ds;
    logic lil, lp;
  } exp_t;

  exp_t sb[$];
  int checks = 0, errors = 0;
  int m_row = 0, m_col = 0;
  logic cur_mode = 0;
  logic [PXW-1:0] pix [H][W];
  logic [DW-1:0] win [5][4];
  logic sq_exp = 0;

  task automatic chk(input string name, input logic [PXW-1:0] act, input logic [PXW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: direct max / rounded mean of the four window values.
  function automatic logic [DW-1:0] ref_pool(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                             input logic [DW-1:0] c, input logic [DW-1:0] d,
                                             input bit sgn, input bit avg);
    logic [DW-1:0] x[4];
    int v[4];
    int r;
    x = '{a, b, c, d};
    for (int i = 0; i < 4; i++) v[i] = sgn ? int'($signed(x[i])) : int'(x[i]);
    if (avg) begin
      r = (v[0] + v[1] + v[2] + v[3] + 2) >>> 2;
    end else begin
      r = v[0];
      for (int i = 1; i < 4; i++) if (v[i] > r) r = v[i];
    end
    return r[DW-1:0];
  endfunction

  function automatic logic [PXW-1:0] gen_pix(input int kind);
    logic [PXW-1:0] d;
    int b, pos, sel;
    d = '0;
    b = (m_row / 2) * 2 + m_col / 2;
    pos = (m_row % 2) * 2 + (m_col % 2);
    for (int k = 0; k < CH; k++) begin
      if (kind == 0) begin
        d[k*DW +: DW] = DW'(m_row * W + m_col + 16 * k);
      end else if (kind == 1) begin
        d[k*DW +: DW] = win[(b + k) % 5][pos];
      end else begin
        sel = $urandom_range(5);
        case (sel)
          0: d[k*DW +: DW] = 8'h00;
          1: d[k*DW +: DW] = 8'h80;
          2: d[k*DW +: DW] = 8'hFF;
          3: d[k*DW +: DW] = 8'h7F;
          default: d[k*DW +: DW] = DW'($urandom);
        endcase
      end
    end
    return d;
  endfunction

  task automatic idle();
    @(posedge CLK); #1;
    DIN_VALID = 0;
    SQUEEZE = 0;
    DIN = PXW'({$urandom});
  endtask

  task automatic send(input logic [PXW-1:0] d, input bit via_sq);
    exp_t e;
    bit avg;
`ifdef POOL_AVG_EN
    avg = cur_mode;
`else
    avg = 0;
`endif
    @(posedge CLK); #1;
    DIN = d;
    DIN_VALID = !via_sq;
    SQUEEZE = via_sq;
    MODE = cur_mode;
    pix[m_row][m_col] = d;
    if (m_row % 2 == 1 && m_col % 2 == 1) begin
      e.cyc = cyc + 1;
      for (int k = 0; k < CH; k++) begin
        e.du[k*DW +: DW] = ref_pool(pix[m_row-1][m_col-1][k*DW +: DW], pix[m_row-1][m_col][k*DW +: DW],
                                    pix[m_row][m_col-1][k*DW +: DW], pix[m_row][m_col][k*DW +: DW], 0, avg);
        e.ds[k*DW +: DW] = ref_pool(pix[m_row-1][m_col-1][k*DW +: DW], pix[m_row-1][m_col][k*DW +: DW],
                                    pix[m_row][m_col-1][k*DW +: DW], pix[m_row][m_col][k*DW +: DW], 1, avg);
      end
      e.lil = (m_col == W - 1);
      e.lp = e.lil && (m_row == H - 1);
      sb.push_back(e);
    end
    if (m_col == W - 1) begin
      m_col = 0;
      m_row = (m_row == H - 1) ? 0 : m_row + 1;
    end else begin
      m_col++;
    end
  endtask

  task automatic run_frame(input int kind, input logic m, input int gap, input int nbeats);
    cur_mode = m;
    for (int i = 0; i < nbeats; i++) begin
      while (int'($urandom_range(99)) < gap) idle();
      send(gen_pix(kind), (gap > 0) && ($urandom_range(3) == 0));
    end
    idle();
  endtask

  task automatic do_reset();
    @(posedge CLK); #1;
    RSTn = 0;
    DIN_VALID = 0;
    SQUEEZE = 0;
    @(posedge CLK); #1;
    chk("reset_out_u", out_u, '0);
    chk("reset_out_s", out_s, '0);
    chk("reset_flags", {v_u, v_s, lil_u, lil_s, lp_u, lp_s, sq_u, sq_s}, '0);
    RSTn = 1;
    m_row = 0;
    m_col = 0;
  endtask

  // Monitor: pops the scoreboard whenever an output is due and checks idle cycles stay quiet.
  initial begin
    @(posedge CLK);
    forever begin
      exp_t e;
      bit lp_now;
      @(negedge CLK);
      lp_now = 0;
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
        e = sb.pop_front();
        chk("missing_output_cycle", PXW'(cyc), PXW'(e.cyc));
      end
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
        e = sb.pop_front();
        chk("valid", {v_u, v_s}, 2'b11);
        chk("out_unsigned", out_u, e.du);
        chk("out_signed", out_s, e.ds);
        chk("last_in_line", {lil_u, lil_s}, {2{e.lil}});
        chk("last_pix", {lp_u, lp_s}, {2{e.lp}});
        lp_now = e.lp;
      end else begin
        chk("idle_flags", {v_u, v_s, lil_u, lil_s, lp_u, lp_s}, '0);
      end
      chk("squeeze_out", {sq_u, sq_s}, {2{sq_exp}});
      sq_exp = !RSTn ? 1'b0 : lp_now ? 1'b1 : NEXT_LAST_PIX ? 1'b0 : sq_exp;
    end
  end

  initial begin
    win = '{'{8'd253, 8'd255, 8'd249, 8'd128},
            '{8'd128, 8'd128, 8'd128, 8'd128},
            '{8'd1,   8'd2,   8'd2,   8'd2},
            '{8'd255, 8'd255, 8'd255, 8'd254},
            '{8'd255, 8'd255, 8'd255, 8'd255}};
    do_reset();
    run_frame(0, 0, 0, W * H);
    run_frame(1, 0, 0, W * H);
    run_frame(1, 1, 0, W * H);
    for (int i = 0; i < 6; i++) run_frame(2, 1'($urandom_range(1)), 50, W * H);
    run_frame(0, 0, 50, W * H);
    run_frame(2, 1, 0, 3 * W + 2);
    do_reset();
    run_frame(0, 1, 0, W * H);
    run_frame(2, 0, 30, W * H);
    repeat (6) idle();
    chk("scoreboard_drained", PXW'(sb.size()), '0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
